// File: rtl/store_unit.sv
// Sequential store requester between the MEM stage and the data-memory port:
// lane-replicates store data, builds byte strobes and holds a req/gnt write until granted.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_HALF   = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_BYTE_U = 3'd3,
        MEM_HALF_U = 3'd4
    } mem_op_e;
endpackage

module store_unit #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [XLEN-1:0]       st_addr,
    input  logic [XLEN-1:0]       st_data,
    input  riscv_pkg::mem_op_e    st_op,
    input  logic                  st_flush,
    output logic                  st_done,
    output logic                  st_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [STRB_W-1:0]     mem_wstrb
);
    import riscv_pkg::*;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                legal_s;
    logic [XLEN-1:0]     lane_wdata_s;
    logic [STRB_W-1:0]   lane_wstrb_s;

    // Lane placement and legality of the store presented this cycle.
    always_comb begin
        legal_s      = 1'b0;
        lane_wdata_s = st_data;
        lane_wstrb_s = 4'b0000;
        case (st_op)
            MEM_BYTE: begin
                legal_s      = 1'b1;
                lane_wdata_s = {4{st_data[7:0]}};
                lane_wstrb_s = 4'b0001 << st_addr[1:0];
            end
            MEM_HALF: begin
                legal_s      = (st_addr[0] == 1'b0);
                lane_wdata_s = {2{st_data[15:0]}};
                lane_wstrb_s = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            MEM_WORD: begin
                legal_s      = (st_addr[1:0] == 2'b00);
                lane_wdata_s = st_data;
                lane_wstrb_s = 4'b1111;
            end
            default: begin
                legal_s      = 1'b0;
                lane_wdata_s = st_data;
                lane_wstrb_s = 4'b0000;
            end
        endcase
    end

    // Next-state and registered-output logic; a grant outranks a flush in REQ.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (st_valid && !st_flush) begin
                    if (legal_s) begin
                        state_d = S_REQ;
                        addr_d  = {st_addr[XLEN-1:2], 2'b00};
                        wdata_d = lane_wdata_s;
                        wstrb_d = lane_wstrb_s;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (st_flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign st_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign st_done   = done_q;
    assign st_err    = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of pending stores.
module tb_store_unit;
    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    riscv_pkg::mem_op_e st_op;
    logic        st_flush;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_cmp;
    int n_fail;

    // Model: at most one pending store, plus the pulses expected after the edge.
    bit          m_pend;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    bit          m_done;
    bit          m_err;

    store_unit dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_op(st_op),
        .st_flush(st_flush), .st_done(st_done), .st_err(st_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store rules from the ISA view: access size, natural alignment, byte lanes.
    function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input int op,
                                      output bit ok, output logic [31:0] wa,
                                      output logic [31:0] wd, output logic [3:0] ws);
        int sz;
        int strb;
        case (op)
            0: sz = 1;
            1: sz = 2;
            2: sz = 4;
            default: sz = 0;
        endcase
        wa = a - (a % 4);
        ok = (sz != 0) && ((a % sz) == 0);
        if (sz == 1)      wd = (d & 32'h0000_00FF) * 32'h0101_0101;
        else if (sz == 2) wd = (d & 32'h0000_FFFF) * 32'h0001_0001;
        else              wd = d;
        strb = ((1 << sz) - 1) << (a % 4);
        ws = strb[3:0];
    endfunction

    // Apply one cycle of inputs (called at a negedge), advance the model, wait to the next negedge.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d, input int op,
                        input bit fl, input bit g, input bit r);
        bit ok;
        logic [31:0] wa, wd;
        logic [3:0] ws;
        st_valid = v; st_addr = a; st_data = d; st_op = riscv_pkg::mem_op_e'(op[2:0]);
        st_flush = fl; mem_gnt = g; rst = r;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_pend = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
        end else if (m_pend) begin
            if (g) begin
                m_pend = 1'b0; m_done = 1'b1;
            end else if (fl) begin
                m_pend = 1'b0;
            end
        end else if (v && !fl) begin
            ref_store(a, d, op, ok, wa, wd, ws);
            if (ok) begin
                m_pend = 1'b1; m_addr = wa; m_wdata = wd; m_wstrb = ws;
            end else begin
                m_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", st_ready); end
        n_cmp++; if ({st_done, st_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {st_done, st_err}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin n_fail++; $display("FAIL reset_mem: got %h %h %b want zeros", mem_addr, mem_wdata, mem_wstrb); end
    endtask

    task automatic test_byte;
        step(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sb_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hEFEF_EFEF) begin n_fail++; $display("FAIL sb_wdata: got %h want efefefef", mem_wdata); end
        n_cmp++; if (mem_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb: got %b want 1000", mem_wstrb); end
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({st_done, mem_req, st_ready} !== 3'b101) begin n_fail++; $display("FAIL sb_done: got done/req/rdy %b want 101", {st_done, mem_req, st_ready}); end
        idle(1);
        n_cmp++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL sb_done_width: got %b want 0", st_done); end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 32'h0000_2002, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({mem_wdata, mem_wstrb} !== {32'h5678_5678, 4'b1100}) begin n_fail++; $display("FAIL sh_lane: got %h/%b want 56785678/1100", mem_wdata, mem_wstrb); end
        n_cmp++; if (mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_addr: got %h want 00002000", mem_addr); end
        step(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 2, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({st_done, st_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_done1: got done/rdy %b want 11", {st_done, st_ready}); end
        step(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({mem_req, st_done} !== 2'b10) begin n_fail++; $display("FAIL b2b_req2: got req/done %b want 10", {mem_req, st_done}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_2004, 32'hCAFE_F00D, 4'b1111}) begin n_fail++; $display("FAIL sw_lane: got %h %h %b want 00002004 cafef00d 1111", mem_addr, mem_wdata, mem_wstrb); end
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", st_done); end
    endtask

    task automatic test_misaligned;
        logic [31:0] ad [5];
        int ops [5];
        ad = '{32'h3001, 32'h3003, 32'h3000, 32'h3002, 32'h3000};
        ops = '{2, 1, 3, 4, 7};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ad[i], $urandom, ops[i], 1'b0, 1'b0, 1'b0);
            n_cmp++; if ({st_err, st_done, mem_req, st_ready} !== 4'b1001) begin n_fail++; $display("FAIL misalign_%0d: got err/done/req/rdy %b want 1001", i, {st_err, st_done, mem_req, st_ready}); end
        end
        idle(1);
        n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b want 0", st_err); end
        n_cmp++; if (mem_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL err_keeps_mem: got %h want cafef00d", mem_wdata); end
    endtask

    task automatic test_stall;
        logic [31:0] d;
        d = $urandom;
        step(1'b1, 32'h0000_4000, d, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({mem_req, st_ready, mem_addr, mem_wdata, mem_wstrb} !== {2'b10, 32'h0000_4000, d, 4'b1111})
                begin n_fail++; $display("FAIL stall_%0d: got req/rdy %b %h %h %b want 10 00004000 %h 1111", i, {mem_req, st_ready}, mem_addr, mem_wdata, mem_wstrb, d); end
            step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b want 1", mem_req); end
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({st_done, mem_req} !== 2'b10) begin n_fail++; $display("FAIL stall_done: got done/req %b want 10", {st_done, mem_req}); end
    endtask

    task automatic test_flush;
        step(1'b1, 32'h0000_5000, 32'h1111_2222, 2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if ({mem_req, st_ready, st_done, st_err} !== 4'b0100) begin n_fail++; $display("FAIL flush_kill: got req/rdy/done/err %b want 0100", {mem_req, st_ready, st_done, st_err}); end
        step(1'b1, 32'h0000_5004, 32'h3333_4444, 2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if ({st_done, mem_req} !== 2'b10) begin n_fail++; $display("FAIL flush_gnt_wins: got done/req %b want 10", {st_done, mem_req}); end
        step(1'b1, 32'h0000_5008, 32'h5555_6666, 2, 1'b1, 1'b0, 1'b0);
        n_cmp++; if ({mem_req, st_ready, st_err} !== 3'b010) begin n_fail++; $display("FAIL flush_idle: got req/rdy/err %b want 010", {mem_req, st_ready, st_err}); end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 32'h0000_6000, 32'h7777_8888, 2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if ({mem_req, st_ready, mem_wstrb, st_done, st_err} !== 8'b0100_0000) begin n_fail++; $display("FAIL rst_mid: got req/rdy/wstrb/done/err %b want 01000000", {mem_req, st_ready, mem_wstrb, st_done, st_err}); end
        step(1'b1, 32'h0000_0000, 32'h0000_00A5, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({mem_req, mem_wstrb, mem_wdata} !== {1'b1, 4'b0001, 32'hA5A5_A5A5}) begin n_fail++; $display("FAIL rst_sb: got req %b wstrb %b wdata %h want 1 0001 a5a5a5a5", mem_req, mem_wstrb, mem_wdata); end
        step(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL rst_sb_done: got %b want 1", st_done); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom_range(0, 255), 2'b00} | $urandom_range(0, 3) | 32'h8000,
                 $urandom, $urandom_range(0, 7), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
            n_cmp++;
            if ({mem_req, st_ready, st_done, st_err} !== {m_pend, !m_pend, m_done, m_err} ||
                (m_pend && {mem_addr, mem_wdata, mem_wstrb} !== {m_addr, m_wdata, m_wstrb}) ||
                (mem_req && mem_wstrb == 4'b0000) || (st_done && st_err)) begin
                n_fail++;
                $display("FAIL rand_%0d: got req/rdy/done/err %b %h %h %b want %b %h %h %b", i,
                         {mem_req, st_ready, st_done, st_err}, mem_addr, mem_wdata, mem_wstrb,
                         {m_pend, !m_pend, m_done, m_err}, m_addr, m_wdata, m_wstrb);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        m_pend = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0; m_done = 1'b0; m_err = 1'b0;
        rst = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        st_op = riscv_pkg::MEM_BYTE; st_flush = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        test_reset;
        test_byte;
        test_back_to_back;
        test_misaligned;
        test_stall;
        test_flush;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-direction counterpart of the load path in the memory stage. It is the sequential store requester between the MEM stage and the data-memory port.
- Accepts one store (address, raw rs2 data, mem_op) per handshake and replicates the data into the correct byte lanes.
- Generates a 4-bit write strobe and word-aligned address, then drives a req/gnt handshake to data memory, holding the request stable until granted.
- Detects misaligned or illegal stores, which issue no memory write, and reports completion or error to the pipeline.

Parameters:
- XLEN, 32, data/address width; only 32 is supported. From riscv_pkg.
- STRB_W, XLEN/8, number of byte-enable bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- st_valid  input  1  pipeline presents a store
- st_ready  output  1  unit can accept; st_valid && st_ready = accept
- st_addr  input  XLEN  byte address of the store
- st_data  input  XLEN  raw rs2 value; the low bits are significant
- st_op  input  mem_op_e  MEM_BYTE / MEM_HALF / MEM_WORD
- st_flush  input  1  kill the outstanding not-yet-granted store
- st_done  output  1  one-cycle pulse: store granted by memory
- st_err  output  1  one-cycle pulse: store rejected (misaligned or illegal op)
- mem_req  output  1  write request to data memory
- mem_gnt  input  1  memory accepts the request this cycle
- mem_addr  output  XLEN  word-aligned address, {st_addr[XLEN-1:2],2'b00}
- mem_wdata  output  XLEN  lane-replicated store data
- mem_wstrb  output  STRB_W  byte enables

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_req=0, st_done=0, st_err=0.
  - mem_addr, mem_wdata and mem_wstrb are all 0.
  - st_ready=1 in the cycle after reset deasserts.
- FSM states:
  - IDLE: st_ready=1, mem_req=0.
  - REQ: st_ready=0, mem_req=1; mem_addr, mem_wdata and mem_wstrb are held stable.
- st_ready is a combinational decode: (state==IDLE).
- Accept in IDLE (st_valid=1), with lane alignment computed from st_addr[1:0] and st_op:
  - MEM_BYTE: wdata={4{st_data[7:0]}}, wstrb=4'b0001<<addr[1:0]. Always aligned.
  - MEM_HALF: wdata={2{st_data[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011. Misaligned if addr[0]=1.
  - MEM_WORD: wdata=st_data, wstrb=4'b1111. Misaligned if addr[1:0]!=0.
  - MEM_BYTE_U, MEM_HALF_U, or any other op: illegal.
- Outcome of an accept:
  - Legal and aligned: register addr/wdata/wstrb, go to REQ. mem_req rises in the next cycle (1-cycle latency).
  - Misaligned or illegal: stay in IDLE, pulse st_err the next cycle, and never raise mem_req. mem_* outputs keep their previous values.
- REQ state:
  - mem_gnt=1: return to IDLE and pulse st_done the next cycle. A new store can be accepted in that same next cycle (back-to-back), so throughput is one store per 2 cycles with zero-wait grant.
  - mem_gnt=0: remain in REQ. Outputs must not change; a bench asserts their stability.
- Flush:
  - st_flush in REQ with mem_gnt=0: return to IDLE, no st_done, no st_err.
  - st_flush and mem_gnt in the same cycle: the grant wins; the store completes and st_done pulses.
  - st_flush in IDLE: suppresses an accept in the same cycle (flush has priority over st_valid). st_ready is unaffected.
- Pulse exclusivity: st_done and st_err are never high in the same cycle, and each is high for exactly one cycle per event.
- mem_wstrb is nonzero whenever mem_req=1. Lanes not covered by wstrb carry replicated data (don't-care to memory).
- rst asserted in any state, including REQ mid-stall: next cycle IDLE, mem_req=0, no st_done or st_err pulse for the dropped store.

Test Plan:
- SB to addr 0x1003, data 0xDEADBEEF, gnt same cycle as mem_req -> mem_addr=0x1000, wdata=0xEFEFEFEF, wstrb=4'b1000; st_done pulse one cycle after grant.
- SH to 0x2002, data 0x12345678, then SW to 0x2004 of 0xCAFEF00D issued back-to-back -> first wdata=0x56785678/wstrb 4'b1100, second wdata=0xCAFEF00D/wstrb 4'b1111, mem_addr=0x2004; two st_done pulses 2 cycles apart.
- Misaligned stores: SW to 0x3001, then SH to 0x3003, then MEM_BYTE_U op -> st_err pulses for each, mem_req never asserted, st_done never asserted.
- SW to 0x4000 with mem_gnt held low for 5 cycles -> mem_req=1 and addr/wdata/wstrb stable for all 5 cycles, st_ready=0; gnt on cycle 6 -> st_done next cycle.
- Flush:
  - SW stalled, st_flush with gnt=0 -> IDLE, no st_done.
  - Repeat with st_flush and gnt in the same cycle -> st_done=1.
- Reset during a stalled REQ -> next cycle mem_req=0, st_ready=1, mem_wstrb=0, no pulses; a subsequent SB to 0x0 completes normally with wstrb=4'b0001.
